lsu: RTL

- Load/store initiator that drives the data-memory `mem` port on behalf of the core pipeline.
- Accepts one request at a time over a valid/ready handshake.
- Naturally aligned requests pass through as a single memory access.
- Misaligned requests are split into aligned accesses, and the result is returned as a one-cycle response pulse.

---
 rtl/config_pkg.sv | 4 +
 rtl/mem_pkg.sv | 25 ++
 rtl/lsu_assemble.sv | 25 ++
 rtl/lsu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Build-wide configuration constants shared by the core and memory slices.
package config_pkg;
  localparam int unsigned DMemAddrWidth = 16;
endpackage

// File: rtl/mem_pkg.sv
// Memory-port types shared by the LSU and the data memory.
package mem_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    RD_LO,
    RD_HI,
    WR_B,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input mem_width_t width, input logic [1:0] offset);
    case (width)
      HALF:    return offset[0];
      WORD:    return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lsu_assemble.sv
// Builds a load result from two consecutive aligned words: byte select,
// truncation to width, then sign or zero extension.
module lsu_assemble
  import mem_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  offset,
  input  mem_width_t  width,
  input  logic        sign_extend,
  output logic [31:0] result
);
  logic [63:0] pair;
  logic [31:0] shifted;

  always_comb begin
    pair    = {hi_word, lo_word};
    shifted = 32'(pair >> {offset, 3'b000});
    case (width)
      BYTE:    result = {{24{sign_extend & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{16{sign_extend & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store initiator for the data-memory port; splits misaligned accesses.
// Define LSU_TRAP_MISALIGNED_EN to trap misaligned requests instead of splitting.
module lsu
  import mem_pkg::*;
#(
  parameter int unsigned AddrWidth = config_pkg::DMemAddrWidth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  mem_width_t           req_width,
  input  logic                 req_sign_extend,
  input  logic [AddrWidth-1:0] req_address,
  input  logic [31:0]          req_data,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_error,
  output logic                 mem_write_enable,
  output mem_width_t           mem_width,
  output logic                 mem_sign_extend,
  output logic [AddrWidth-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out,
  input  logic                 mem_alignment_error
);
  lsu_state_t  state;
  mem_width_t  r_width;
  logic        r_sext;
  logic [1:0]  r_off;
  logic [31:0] r_data;
  logic [31:0] lo_word;
  logic [1:0]  bytes_left;
  logic        err;
  logic [31:0] assembled;

  lsu_assemble u_assemble (
    .lo_word    (lo_word),
    .hi_word    (mem_data_out),
    .offset     (r_off),
    .width      (r_width),
    .sign_extend(r_sext),
    .result     (assembled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_error        <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_width        <= BYTE;
      mem_sign_extend  <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      r_width          <= BYTE;
      r_sext           <= 1'b0;
      r_off            <= '0;
      r_data           <= '0;
      lo_word          <= '0;
      bytes_left       <= '0;
      err              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            err       <= 1'b0;
            r_width   <= req_width;
            r_sext    <= req_sign_extend;
            r_off     <= req_address[1:0];
            r_data    <= req_data;
            if (!is_misaligned(req_width, req_address[1:0])) begin
              state            <= ACC;
              mem_write_enable <= req_write;
              mem_width        <= req_width;
              mem_sign_extend  <= req_sign_extend;
              mem_address      <= req_address;
              mem_data_in      <= req_data;
            end
`ifdef LSU_TRAP_MISALIGNED_EN
            else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= '0;
            end
`else
            else if (!req_write) begin
              state            <= RD_LO;
              mem_write_enable <= 1'b0;
              mem_width        <= WORD;
              mem_sign_extend  <= 1'b0;
              mem_address      <= {req_address[AddrWidth-1:2], 2'b00};
            end else begin
              state            <= WR_B;
              mem_write_enable <= 1'b1;
              mem_width        <= BYTE;
              mem_sign_extend  <= 1'b0;
              mem_address      <= req_address;
              mem_data_in      <= {24'h0, req_data[7:0]};
              bytes_left       <= (req_width == HALF) ? 2'd1 : 2'd3;
            end
`endif
          end
        end
        ACC: begin
          state            <= RESP;
          rsp_valid        <= 1'b1;
          rsp_error        <= err | mem_alignment_error;
          rsp_data         <= mem_write_enable ? '0 : mem_data_out;
          mem_write_enable <= 1'b0;
        end
        RD_LO: begin
          state       <= RD_HI;
          lo_word     <= mem_data_out;
          err         <= err | mem_alignment_error;
          mem_address <= mem_address + AddrWidth'(4);
        end
        RD_HI: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_error <= err | mem_alignment_error;
          rsp_data  <= assembled;
        end
        WR_B: begin
          err <= err | mem_alignment_error;
          if (bytes_left == 2'd0) begin
            state            <= RESP;
            rsp_valid        <= 1'b1;
            rsp_error        <= err | mem_alignment_error;
            rsp_data         <= '0;
            mem_write_enable <= 1'b0;
          end else begin
            // r_data shifts down so the next byte to store is always at [15:8]
            bytes_left  <= bytes_left - 2'd1;
            mem_address <= mem_address + AddrWidth'(1);
            mem_data_in <= {24'h0, r_data[15:8]};
            r_data      <= r_data >> 8;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
